franken_uart_bus: RTL and testbench

//  Memory-mapped UART responder on the franken_riscv data bus.

---
 rtl/franken_uart_bus_pkg.sv | 34 +++
 rtl/franken_uart_rx_core.sv | 120 ++++++++++++
 rtl/franken_uart_bus.sv | 200 ++++++++++++++++++++
 tb/tb_franken_uart_bus.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/franken_uart_bus_pkg.sv
// Shared definitions for the franken_uart_bus UART responder:
// register offsets, STATUS bit positions and the TX/RX state encodings.
package franken_uart_bus_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_VALID   = 1;
    localparam int STAT_RX_OVERRUN = 2;
    localparam int STAT_FRAME_ERR  = 3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // The UART owns a 16-byte window; only the upper 28 address bits are compared.
    function automatic logic window_hit(input logic [31:0] a, input logic [31:0] base);
        return (a[31:4] == base[31:4]);
    endfunction

endpackage

// File: rtl/franken_uart_rx_core.sv
// Receive path: two-flop synchronizer on RXD followed by an 8N1 deserializer.
// Emits a one-cycle done pulse with the byte, or a one-cycle frame error pulse.
module franken_uart_rx_core
    import franken_uart_bus_pkg::*;
#(
    parameter int DIV = 16
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(DIV / 2 - 1);

    logic [1:0]       sync_q;
    logic             rxd_prev;
    logic             rx_s;
    logic             rx_fall;

    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]       rx_bit, rx_bit_nxt;
    logic [7:0]       rx_shift, rx_shift_nxt;

    assign rx_s    = sync_q[1];
    assign rx_fall = rxd_prev & ~rx_s;
    assign rx_byte = rx_shift;

    // Bring RXD into the clock domain and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], rxd};
            rxd_prev <= sync_q[1];
        end
    end

    // Receiver state, bit-period counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    // Half a bit after the falling edge we confirm the start bit, then sample each bit mid-period.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_done      = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_MAX) begin
                    rx_cnt_nxt = '0;
                    if (rx_s) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_state_nxt = RX_DATA;
                        rx_bit_nxt   = '0;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_MAX) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_MAX) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_s) begin
                        rx_done = 1'b1;
                    end else begin
                        rx_frame_err = 1'b1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/franken_uart_bus.sv
// Memory-mapped UART responder for the franken_riscv data bus.
// Holds the TX serializer, register decode, status flags and the store stall.
module franken_uart_bus
    import franken_uart_bus_pkg::*;
#(
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        rbusy,
    input  logic        RXD,
    output logic        TXD
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic             hit;
    logic [1:0]       reg_off;
    logic             tx_hit_wr;
    logic             tx_accept;
    logic             stat_wr;
    logic             rx_rd;
    logic             tx_busy;

    tx_state_t        tx_state, tx_state_nxt;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]       tx_bit, tx_bit_nxt;
    logic [7:0]       tx_shift, tx_shift_nxt;

    logic             rx_valid;
    logic             rx_overrun;
    logic             frame_err;
    logic [7:0]       rx_byte;

    logic [7:0]       rx_core_byte;
    logic             rx_done;
    logic             rx_ferr;
    logic             rx_load;
    logic             overrun_set;

    logic             unused_bits;

    assign hit       = window_hit(addr, BASE_ADDR);
    assign reg_off   = addr[3:2];
    assign tx_hit_wr = mem_write & hit & (reg_off == REG_TXDATA);
    assign tx_busy   = (tx_state != TX_IDLE);
    assign tx_accept = tx_hit_wr & byte_enable[0] & ~tx_busy;
    assign rbusy     = tx_hit_wr & tx_busy;
    assign stat_wr   = mem_write & hit & (reg_off == REG_STATUS);
    assign rx_rd     = mem_read & hit & (reg_off == REG_RXDATA);

    // A read of RXDATA frees the holding register, so a byte finishing that cycle is not an overrun.
    assign rx_load     = rx_done & (~rx_valid | rx_rd);
    assign overrun_set = rx_done & rx_valid & ~rx_rd;

    assign unused_bits = ^{addr[1:0], write_data[31:8], byte_enable[3:1]};

    franken_uart_rx_core #(
        .DIV(DIV)
    ) u_rx_core (
        .clk          (clk),
        .reset        (reset),
        .rxd          (RXD),
        .rx_byte      (rx_core_byte),
        .rx_done      (rx_done),
        .rx_frame_err (rx_ferr)
    );

    // Register read mux; anything outside the window or in the reserved slot reads as zero.
    always_comb begin
        read_data = '0;
        if (hit) begin
            case (reg_off)
                REG_STATUS: begin
                    read_data[STAT_TX_BUSY]    = tx_busy;
                    read_data[STAT_RX_VALID]   = rx_valid;
                    read_data[STAT_RX_OVERRUN] = rx_overrun;
                    read_data[STAT_FRAME_ERR]  = frame_err;
                end
                REG_RXDATA: read_data = {24'b0, rx_byte};
                default:    read_data = '0;
            endcase
        end
    end

    // Transmitter state, bit-period counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    // Each frame phase lasts DIV clocks; the shift register presents the current data bit in bit 0.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        case (tx_state)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_nxt = TX_START;
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = write_data[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_MAX) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_MAX) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == CNT_MAX) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Line level follows the frame phase; idle and stop are high.
    always_comb begin
        TXD = 1'b1;
        case (tx_state)
            TX_START: TXD = 1'b0;
            TX_DATA:  TXD = tx_shift[0];
            default:  TXD = 1'b1;
        endcase
    end

    // Receive holding register and sticky flags; a flag being set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_byte  <= rx_core_byte;
                rx_valid <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end

            if (overrun_set) begin
                rx_overrun <= 1'b1;
            end else if (stat_wr && write_data[STAT_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end

            if (rx_ferr) begin
                frame_err <= 1'b1;
            end else if (stat_wr && write_data[STAT_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_franken_uart_bus.sv
// Self-checking bench for franken_uart_bus at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_franken_uart_bus;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'd4;
    localparam logic [31:0] A_RX  = BASE + 32'd8;
    localparam logic [31:0] A_RSV = BASE + 32'd12;
    localparam int          BITCLK = 16;
    localparam int          FRAMECLK = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = A_ST;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [3:0]  byte_enable = 4'h0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        rbusy;
    logic        RXD = 1'b1;
    logic        TXD;

    int errors = 0;
    int checks = 0;

    franken_uart_bus #(
        .CLK_HZ    (16),
        .BAUD      (1),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .byte_enable (byte_enable),
        .write_data  (write_data),
        .read_data   (read_data),
        .rbusy       (rbusy),
        .RXD         (RXD),
        .TXD         (TXD)
    );

    always #5 clk = ~clk;

    // Compare one value and report it if it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Transmit model: a frame is ten 16-clock bit slots starting on the clock after the accepting edge.
    int         cyc = 0;
    int         tx_a = 0;
    bit         tx_started = 0;
    logic [9:0] tx_frame = 10'h3FF;

    function automatic bit modelBusy(input int n);
        return tx_started && ((n - tx_a) >= 0) && ((n - tx_a) < FRAMECLK);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_started = 0;
        end else begin
            if (mem_write && (addr[31:4] == BASE[31:4]) && (addr[3:2] == 2'd0)
                && byte_enable[0] && !modelBusy(cyc)) begin
                tx_a       = cyc + 1;
                tx_frame   = {1'b1, write_data[7:0], 1'b0};
                tx_started = 1;
            end
            cyc = cyc + 1;
        end
    end

    // Every cycle: TXD, rbusy and (when STATUS is addressed) tx_busy against the model.
    always @(negedge clk) begin : compare_proc
        bit   exp_busy;
        logic exp_txd;
        logic exp_rbusy;
        exp_busy  = modelBusy(cyc);
        exp_txd   = exp_busy ? tx_frame[(cyc - tx_a) / BITCLK] : 1'b1;
        exp_rbusy = mem_write && (addr[31:4] == BASE[31:4]) && (addr[3:2] == 2'd0) && exp_busy;
        checkOutput("txd_model", {31'b0, TXD}, {31'b0, exp_txd});
        checkOutput("rbusy_model", {31'b0, rbusy}, {31'b0, exp_rbusy});
        if (addr == A_ST) begin
            checkOutput("tx_busy_model", {31'b0, read_data[0]}, {31'b0, exp_busy});
        end
    end

    // Bus store; holds the store while rbusy is asserted and returns the stall count.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, output int stalls);
        stalls = 0;
        @(posedge clk);
        #2;
        addr        = a;
        write_data  = d;
        byte_enable = 4'hF;
        mem_write   = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!rbusy) break;
            stalls++;
        end
        checkOutput("store_accept_rbusy", {31'b0, rbusy}, 32'h0);
        @(posedge clk);
        #2;
        mem_write   = 1'b0;
        byte_enable = 4'h0;
        write_data  = 32'h0;
        addr        = A_ST;
    endtask

    // Bus load (rd=1) or plain address peek (rd=0); data sampled mid-cycle.
    task automatic busRead(input logic [31:0] a, input logic rd, output logic [31:0] d);
        @(posedge clk);
        #2;
        addr     = a;
        mem_read = rd;
        @(negedge clk);
        d = read_data;
        @(posedge clk);
        #2;
        mem_read = 1'b0;
        addr     = A_ST;
    endtask

    // Drive one 8N1 frame on RXD with a chosen stop level, then idle high.
    task automatic sendRx(input logic [7:0] b, input logic stopb);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            RXD = bits[i];
            repeat (BITCLK - 1) @(posedge clk);
        end
        @(posedge clk);
        #2;
        RXD = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [9:0]  seq55;
        int          stalls;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        checkOutput("reset_txd", {31'b0, TXD}, 32'h1);
        checkOutput("reset_rbusy", {31'b0, rbusy}, 32'h0);
        checkOutput("reset_status", read_data, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        busRead(A_RX, 1'b0, rd);
        checkOutput("reset_rxdata", rd, 32'h0);

        // Test 1: single 0x55 frame, pinned slot by slot
        $display("[TB] test 1: TX 0x55");
        seq55 = 10'b1010101010;
        applyStimulus(A_TX, 32'h0000_0055, stalls);
        checkOutput("t1_stalls", stalls, 0);
        repeat (8) @(posedge clk);
        #3;
        checkOutput("t1_status_busy", read_data, 32'h1);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("t1_txd_slot%0d", k), {31'b0, TXD}, {31'b0, seq55[k]});
            repeat (BITCLK) @(posedge clk);
            #3;
        end
        checkOutput("t1_status_idle", read_data, 32'h0);
        checkOutput("t1_txd_idle", {31'b0, TXD}, 32'h1);

        // Test 2: back-to-back stores stall until the first frame ends
        $display("[TB] test 2: TX 0x41 then 0x42");
        applyStimulus(A_TX, 32'h0000_0041, stalls);
        applyStimulus(A_TX, 32'h0000_0042, stalls);
        checkOutput("t2_stalls", stalls, 159);
        repeat (FRAMECLK + 5) @(posedge clk);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t2_status_idle", rd, 32'h0);

        // Test 3: receive 0xA3
        $display("[TB] test 3: RX 0xA3");
        sendRx(8'hA3, 1'b1);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t3_status", rd, 32'h2);
        busRead(32'h2000_0008, 1'b1, rd);
        checkOutput("t3_outside_window", rd, 32'h0);
        busRead(A_RSV, 1'b1, rd);
        checkOutput("t3_reserved", rd, 32'h0);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t3_status_kept", rd, 32'h2);
        busRead(A_RX, 1'b1, rd);
        checkOutput("t3_rxdata", rd, 32'h0000_00A3);
        busRead(A_RX, 1'b1, rd);
        checkOutput("t3_rxdata_again", rd, 32'h0000_00A3);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t3_status_cleared", rd, 32'h0);

        // Test 4: overrun
        $display("[TB] test 4: RX overrun");
        sendRx(8'h11, 1'b1);
        sendRx(8'h22, 1'b1);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t4_status", rd, 32'h6);
        busRead(A_RX, 1'b0, rd);
        checkOutput("t4_rxdata_first", rd, 32'h0000_0011);
        applyStimulus(A_ST, 32'h0000_0004, stalls);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t4_status_w1c", rd, 32'h2);
        busRead(A_RX, 1'b1, rd);
        checkOutput("t4_rxdata_read", rd, 32'h0000_0011);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t4_status_clear", rd, 32'h0);

        // Test 5: frame error and start-bit glitch
        $display("[TB] test 5: frame error and glitch");
        sendRx(8'h5A, 1'b0);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t5_status_ferr", rd, 32'h8);
        applyStimulus(A_ST, 32'h0000_0008, stalls);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t5_status_w1c", rd, 32'h0);
        @(posedge clk);
        #2;
        RXD = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        RXD = 1'b1;
        repeat (40) @(posedge clk);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t5_glitch_status", rd, 32'h0);
        busRead(A_RX, 1'b0, rd);
        checkOutput("t5_glitch_rxdata", rd, 32'h0000_0011);

        // Test 6: reset in the middle of a TX frame
        $display("[TB] test 6: reset mid-frame");
        sendRx(8'h77, 1'b1);
        applyStimulus(A_TX, 32'h0000_003C, stalls);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("t6_status_before", read_data, 32'h3);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t6_txd_reset", {31'b0, TXD}, 32'h1);
        checkOutput("t6_rbusy_reset", {31'b0, rbusy}, 32'h0);
        checkOutput("t6_status_reset", read_data, 32'h0);
        addr = A_RX;
        #1;
        checkOutput("t6_rxdata_reset", read_data, 32'h0);
        addr = A_ST;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(A_TX, 32'h0000_0096, stalls);
        checkOutput("t6_new_stalls", stalls, 0);
        repeat (FRAMECLK + 5) @(posedge clk);
        busRead(A_ST, 1'b0, rd);
        checkOutput("t6_status_end", rd, 32'h0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
